// File: rtl/ct_spsram_acc_ctrl_if.sv
// ---------------------------------------------------------------------------
// Interfaces for the single-port SRAM access controller.
//
// ct_spsram_acc_ctrl_if : request/response stream between a host and the
//   controller.
//   master modport (host)       drives req_vld/req_wr/req_addr/req_wdata/
//                               req_wmask/rsp_rdy, observes req_rdy,
//                               rsp_vld/rsp_rdata/init_done.
//   slave modport (controller)  the mirror image.
//
// ct_spsram_pin_if : SRAM macro pins (active-low enables).
//   master modport (controller) drives A/CEN/GWEN/WEN/D, observes Q.
//   slave modport (SRAM macro)  the mirror image.
// ---------------------------------------------------------------------------
interface ct_spsram_acc_ctrl_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 128
) ();
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  init_done;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata, init_done
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata, init_done
  );
endinterface

interface ct_spsram_pin_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 128
) ();
  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [DATA_WIDTH-1:0] WEN;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;

  modport master (
    output A, CEN, GWEN, WEN, D,
    input  Q
  );

  modport slave (
    input  A, CEN, GWEN, WEN, D,
    output Q
  );
endinterface

// File: rtl/ct_spsram_acc_ctrl.sv
// ---------------------------------------------------------------------------
// ct_spsram_acc_ctrl
// Controller for a single-port SRAM macro. Converts a valid/ready request
// stream into registered SRAM pin activity, returns read data in request
// order through a small response FIFO, and throttles reads with a credit
// count so the FIFO can never overflow. After reset the whole array is
// zero-filled (INIT_EN=1) before any request is accepted.
//
// Ports
//   i_clk  in   rising-edge clock
//   i_rst  in   synchronous active-high reset
//   bus    slave modport of ct_spsram_acc_ctrl_if (requests, responses,
//          init_done)
//   sram   master modport of ct_spsram_pin_if (A/CEN/GWEN/WEN/D out, Q in)
//
// Read timing: accept in t, pins in t+1, Q valid in t+2 and captured at the
// end of t+2, rsp_vld from t+3.
// RSP_DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module ct_spsram_acc_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 128,
  parameter int RSP_DEPTH  = 4,
  parameter int INIT_EN    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ct_spsram_acc_ctrl_if.slave   bus,
  ct_spsram_pin_if.master       sram
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int OW = $clog2(RSP_DEPTH + 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t ST_RST = (INIT_EN != 0) ? ST_INIT : ST_RUN;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fill_cnt;
  logic                  r_init_done;
  logic [OW-1:0]         r_outst;
  logic [PW:0]           r_wptr;
  logic [PW:0]           r_rptr;
  logic [DATA_WIDTH-1:0] r_fifo [RSP_DEPTH];
  logic                  r_rd_vld_p1;
  logic                  r_rd_vld_p2;

  logic [ADDR_WIDTH-1:0] r_a;
  logic                  r_cen;
  logic                  r_gwen;
  logic [DATA_WIDTH-1:0] r_wen;
  logic [DATA_WIDTH-1:0] r_d;

  logic [ADDR_WIDTH-1:0] w_a_nxt;
  logic                  w_cen_nxt;
  logic                  w_gwen_nxt;
  logic [DATA_WIDTH-1:0] w_wen_nxt;
  logic [DATA_WIDTH-1:0] w_d_nxt;

  logic                  w_req_rdy;
  logic                  w_acc;
  logic                  w_acc_rd;
  logic                  w_fifo_empty;
  logic                  w_pop;
  logic                  w_fill_last;

  // Credit check: a read may only be accepted while a FIFO slot is
  // guaranteed for it, counting reads still travelling through the pins.
  assign w_req_rdy    = r_init_done & (r_outst < OW'(RSP_DEPTH));
  assign w_acc        = bus.req_vld & w_req_rdy;
  assign w_acc_rd     = w_acc & ~bus.req_wr;
  assign w_fifo_empty = (r_wptr == r_rptr);
  assign w_pop        = ~w_fifo_empty & bus.rsp_rdy;
  assign w_fill_last  = &r_fill_cnt;

  // ---- FSM: state register ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- FSM: next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (w_fill_last) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RST;
    endcase
  end

  // ---- FSM: next pin values ----
  // Idle cycles release the enables but keep A and D, so the address/data
  // buses only toggle when a real access happens.
  always_comb begin
    w_a_nxt    = r_a;
    w_cen_nxt  = 1'b1;
    w_gwen_nxt = 1'b1;
    w_wen_nxt  = '1;
    w_d_nxt    = r_d;
    case (r_state)
      ST_INIT: begin
        w_a_nxt    = r_fill_cnt;
        w_cen_nxt  = 1'b0;
        w_gwen_nxt = 1'b0;
        w_wen_nxt  = '0;
        w_d_nxt    = '0;
      end
      ST_RUN: begin
        if (w_acc) begin
          w_a_nxt   = bus.req_addr;
          w_cen_nxt = 1'b0;
          if (bus.req_wr) begin
            w_gwen_nxt = 1'b0;
            w_wen_nxt  = ~bus.req_wmask;
            w_d_nxt    = bus.req_wdata;
          end
        end
      end
      default: ;
    endcase
  end

  // Fill address counter; it wraps back to 0 as the FSM leaves INIT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fill_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_fill_cnt <= r_fill_cnt + ADDR_WIDTH'(1);
    end
  end

  // Registered so that it rises the cycle after the last fill write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_init_done <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_init_done <= 1'b1;
    end
  end

  // ---- stage p0 -> p1: SRAM pin registers ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a    <= '0;
      r_cen  <= 1'b1;
      r_gwen <= 1'b1;
      r_wen  <= '1;
      r_d    <= '0;
    end else begin
      r_a    <= w_a_nxt;
      r_cen  <= w_cen_nxt;
      r_gwen <= w_gwen_nxt;
      r_wen  <= w_wen_nxt;
      r_d    <= w_d_nxt;
    end
  end

  // ---- stage p1 -> p2: read-valid tracking alongside the macro latency ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_vld_p1 <= 1'b0;
      r_rd_vld_p2 <= 1'b0;
    end else begin
      r_rd_vld_p1 <= w_acc_rd;
      r_rd_vld_p2 <= r_rd_vld_p1;
    end
  end

  // ---- stage p2 -> FIFO: capture Q ----
  always_ff @(posedge i_clk) begin
    if (r_rd_vld_p2) begin
      r_fifo[r_wptr[PW-1:0]] <= sram.Q;
    end
  end

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (r_rd_vld_p2) r_wptr <= r_wptr + (PW+1)'(1);
      if (w_pop)       r_rptr <= r_rptr + (PW+1)'(1);
    end
  end

  // Outstanding reads: accepted but not yet popped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_outst <= '0;
    end else begin
      case ({w_acc_rd, w_pop})
        2'b10:   r_outst <= r_outst + OW'(1);
        2'b01:   r_outst <= r_outst - OW'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  assign bus.req_rdy   = w_req_rdy;
  assign bus.rsp_vld   = ~w_fifo_empty;
  assign bus.rsp_rdata = r_fifo[r_rptr[PW-1:0]];
  assign bus.init_done = r_init_done;

  assign sram.A    = r_a;
  assign sram.CEN  = r_cen;
  assign sram.GWEN = r_gwen;
  assign sram.WEN  = r_wen;
  assign sram.D    = r_d;

endmodule

// File: tb/tb_ct_spsram_acc_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for ct_spsram_acc_ctrl (ADDR_WIDTH=4, DATA_WIDTH=8, RSP_DEPTH=4).
// A behavioural SRAM macro sits on the pin interface. The reference model
// is an ideal word array updated at request-accept time plus a queue of
// expected responses, each tagged with the cycle it may first appear.
// ---------------------------------------------------------------------------
module tb_ct_spsram_acc_ctrl;
  localparam int AW     = 4;
  localparam int DW     = 8;
  localparam int DEPTH  = 4;
  localparam int NWORDS = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ct_spsram_acc_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ct_spsram_pin_if      #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sram ();

  ct_spsram_acc_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH), .INIT_EN(1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus),
    .sram (sram)
  );

  // Behavioural SRAM macro: one-cycle read latency, bitwise write enables.
  // Q carries random junk whenever the previous cycle was not a read.
  logic [DW-1:0] mem_arr [NWORDS];
  logic [DW-1:0] q_r;
  logic          seed;
  assign sram.Q = q_r;

  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < NWORDS; i++) mem_arr[i] <= DW'($urandom);
      q_r <= DW'($urandom);
    end else begin
      if (!sram.CEN && !sram.GWEN)
        mem_arr[sram.A] <= (mem_arr[sram.A] & sram.WEN) | (sram.D & ~sram.WEN);
      if (!sram.CEN && sram.GWEN) q_r <= mem_arr[sram.A];
      else                        q_r <= DW'($urandom);
    end
  end

  // Reference model state
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic [DW-1:0] ref_mem [NWORDS];
  exp_t          expq [$];
  int            cyc;
  bit            run_chk;
  int            n_err = 0;
  int            n_chk = 0;
  int            n_acc = 0;
  int            n_pop = 0;
  logic [DW-1:0] last_rsp;
  logic          e_cen, e_gwen;
  logic [AW-1:0] e_a;
  logic [DW-1:0] e_wen, e_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    bus.req_vld   = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
  endtask

  task automatic set_req(input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] wm);
    bus.req_vld   = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_wmask = wm;
  endtask

  // One clock cycle in RUN. Called at the falling edge with inputs driven.
  task automatic tick();
    bit   acc, pop, exp_vld;
    exp_t e;
    acc = bus.req_vld && bus.req_rdy;
    pop = bus.rsp_vld && bus.rsp_rdy;
    if (run_chk) begin
      exp_vld = 1'b0;
      if (expq.size() > 0) exp_vld = (expq[0].due <= cyc);
      chk("req_rdy", 32'(bus.req_rdy), 32'(expq.size() < DEPTH));
      chk("rsp_vld", 32'(bus.rsp_vld), 32'(exp_vld));
      if (pop && expq.size() > 0) begin
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(expq[0].data));
        last_rsp = bus.rsp_rdata;
        n_pop++;
        void'(expq.pop_front());
      end
    end
    if (acc) begin
      n_acc++;
      e_cen = 1'b0;
      e_a   = bus.req_addr;
      if (bus.req_wr) begin
        ref_mem[bus.req_addr] = (ref_mem[bus.req_addr] & ~bus.req_wmask) |
                                (bus.req_wdata & bus.req_wmask);
        e_gwen = 1'b0;
        e_wen  = ~bus.req_wmask;
        e_d    = bus.req_wdata;
      end else begin
        e.data = ref_mem[bus.req_addr];
        e.due  = cyc + 3;
        expq.push_back(e);
        e_gwen = 1'b1;
      end
    end else begin
      e_cen  = 1'b1;
      e_gwen = 1'b1;
      e_wen  = '1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (run_chk) begin
      chk("pin_cen",  32'(sram.CEN),  32'(e_cen));
      chk("pin_gwen", 32'(sram.GWEN), 32'(e_gwen));
      chk("pin_a",    32'(sram.A),    32'(e_a));
      chk("pin_d",    32'(sram.D),    32'(e_d));
      if (e_cen || !e_gwen) chk("pin_wen", 32'(sram.WEN), 32'(e_wen));
    end
  endtask

  task automatic drain();
    set_idle();
    bus.rsp_rdy = 1'b1;
    for (int k = 0; k < 40 && expq.size() > 0; k++) tick();
    tick();
    chk("drain_left", 32'(expq.size()), 32'd0);
  endtask

  // Releases reset (must be held high on entry) and checks the fill sweep.
  // Requests are presented throughout to show they are ignored.
  task automatic do_init();
    run_chk = 1'b0;
    expq.delete();
    set_req(1'b1, 4'd7, 8'h5A, 8'hFF);
    bus.rsp_rdy = 1'b1;
    rst = 1'b0;
    for (int k = 1; k <= NWORDS; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("init_cen",  32'(sram.CEN),      32'd0);
      chk("init_gwen", 32'(sram.GWEN),     32'd0);
      chk("init_a",    32'(sram.A),        32'(k - 1));
      chk("init_wen",  32'(sram.WEN),      32'd0);
      chk("init_d",    32'(sram.D),        32'd0);
      chk("init_done", 32'(bus.init_done), 32'd0);
      chk("init_rdy",  32'(bus.req_rdy),   32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("init_done_hi", 32'(bus.init_done), 32'd1);
    chk("init_end_cen", 32'(sram.CEN),      32'd1);
    set_idle();
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = '0;
    cyc     = NWORDS + 1;
    e_cen   = 1'b1;
    e_gwen  = 1'b1;
    e_wen   = '1;
    e_a     = AW'(NWORDS - 1);
    e_d     = '0;
    run_chk = 1'b1;
  endtask

  initial begin
    int a0, p0;
    rst  = 1'b1;
    seed = 1'b1;
    set_idle();
    bus.rsp_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    seed = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset values
    chk("rst_req_rdy",   32'(bus.req_rdy),   32'd0);
    chk("rst_rsp_vld",   32'(bus.rsp_vld),   32'd0);
    chk("rst_init_done", 32'(bus.init_done), 32'd0);
    chk("rst_cen",       32'(sram.CEN),      32'd1);
    chk("rst_gwen",      32'(sram.GWEN),     32'd1);
    chk("rst_wen",       32'(sram.WEN),      32'hFF);
    chk("rst_a",         32'(sram.A),        32'd0);
    chk("rst_d",         32'(sram.D),        32'd0);

    // 1: zero-fill, then every address reads back 0
    do_init();
    p0 = n_pop;
    bus.rsp_rdy = 1'b1;
    for (int i = 0; i < NWORDS; i++) begin
      set_req(1'b0, AW'(i), 8'h00, 8'h00);
      tick();
      if (bus.rsp_vld) chk("t1_zero", 32'(bus.rsp_rdata), 32'd0);
    end
    drain();
    chk("t1_reads", 32'(n_pop - p0), 32'd16);

    // 2: write then read the same address, fixed latency
    set_req(1'b1, 4'd5, 8'hA5, 8'hFF);
    tick();
    set_req(1'b0, 4'd5, 8'h00, 8'h00);
    tick();
    set_idle();
    tick();
    tick();
    chk("t2_vld",  32'(bus.rsp_vld),   32'd1);
    chk("t2_data", 32'(bus.rsp_rdata), 32'hA5);
    drain();

    // 3: masked write, and a write with an empty mask
    set_req(1'b1, 4'd3, 8'hFF, 8'hFF);
    tick();
    set_req(1'b1, 4'd3, 8'h00, 8'h0F);
    tick();
    set_req(1'b0, 4'd3, 8'h00, 8'h00);
    tick();
    drain();
    chk("t3_masked", 32'(last_rsp), 32'hF0);
    set_req(1'b1, 4'd5, 8'h00, 8'h00);
    tick();
    chk("t3_nomask_cen", 32'(sram.CEN), 32'd0);
    set_req(1'b0, 4'd5, 8'h00, 8'h00);
    tick();
    drain();
    chk("t3_nomask", 32'(last_rsp), 32'hA5);

    // 4: backpressure with distinct contents at addresses 0..5
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, AW'(i), DW'(8'h10 + i), 8'hFF);
      tick();
    end
    set_idle();
    bus.rsp_rdy = 1'b0;
    a0 = n_acc;
    for (int s = 0; s < 6; s++) begin
      set_req(1'b0, AW'(n_acc - a0), 8'h00, 8'h00);
      tick();
    end
    chk("t4_acc4", 32'(n_acc - a0), 32'd4);
    chk("t4_full_rdy", 32'(bus.req_rdy), 32'd0);
    p0 = n_pop;
    bus.rsp_rdy = 1'b1;
    for (int s = 0; s < 30 && (n_acc - a0) < 6; s++) begin
      set_req(1'b0, AW'(n_acc - a0), 8'h00, 8'h00);
      tick();
    end
    chk("t4_acc6", 32'(n_acc - a0), 32'd6);
    drain();
    chk("t4_pops", 32'(n_pop - p0), 32'd6);
    chk("t4_last", 32'(last_rsp), 32'h15);

    // 5: streaming back-to-back reads
    p0 = n_pop;
    bus.rsp_rdy = 1'b1;
    for (int i = 0; i < NWORDS; i++) begin
      chk("t5_rdy", 32'(bus.req_rdy), 32'd1);
      set_req(1'b0, AW'(i), 8'h00, 8'h00);
      tick();
    end
    drain();
    chk("t5_pops", 32'(n_pop - p0), 32'd16);

    // Random traffic
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 3) != 0)
        set_req(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
      else
        set_idle();
      bus.rsp_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // 6: reset with reads outstanding
    bus.rsp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b0, AW'(i), 8'h00, 8'h00);
      tick();
    end
    set_idle();
    tick();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rsp_vld",   32'(bus.rsp_vld),   32'd0);
    chk("t6_cen",       32'(sram.CEN),      32'd1);
    chk("t6_req_rdy",   32'(bus.req_rdy),   32'd0);
    chk("t6_init_done", 32'(bus.init_done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    do_init();
    p0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      bus.rsp_rdy = 1'b1;
      set_req(1'b0, AW'(i), 8'h00, 8'h00);
      tick();
    end
    drain();
    chk("t6_pops", 32'(n_pop - p0), 32'd8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
